// File: rtl/pc_sequencer.sv
// pc_sequencer: resolves one PC-update request per instruction and drives the
// PC-source mux select, PC/EPC write enables and the mux jump-address input.
// Exceptions save EPC and fetch the handler address byte from the vector table.
module pc_sequencer #(
  parameter int unsigned VEC_BASE = 253
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [2:0]  pc_op,
  input  logic        zero,
  input  logic        gt,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [25:0] instr_index,
  input  logic        mem_ready,
  input  logic [7:0]  mem_data,
  output logic [1:0]  pc_source,
  output logic        pc_write,
  output logic        epc_write,
  output logic [31:0] epc_data,
  output logic [31:0] jump_addr,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [1:0]  exc_cause,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] VEC = 32'(VEC_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESOLVE,
    S_EXC_SAVE,
    S_EXC_READ,
    S_EXC_LOAD
  } state_t;

  typedef enum logic [2:0] {
    OP_SEQ = 3'b000,
    OP_BEQ = 3'b001,
    OP_BNE = 3'b010,
    OP_BLE = 3'b011,
    OP_BGT = 3'b100,
    OP_J   = 3'b101,
    OP_JR  = 3'b110,
    OP_RTE = 3'b111
  } pc_op_t;

  state_t      r_state, w_state_nxt;

  logic [1:0]  r_pc_source, w_pc_source;
  logic        r_pc_write,  w_pc_write;
  logic        r_epc_write, w_epc_write;
  logic [31:0] r_epc_data,  w_epc_data;
  logic [31:0] r_jump_addr, w_jump_addr;
  logic        r_mem_read,  w_mem_read;
  logic [31:0] r_mem_addr,  w_mem_addr;
  logic [1:0]  r_exc_cause, w_exc_cause;
  logic        r_busy,      w_busy;
  logic        r_done,      w_done;

  logic        w_any_exc;
  logic [31:0] w_vec_offset;

  assign w_any_exc    = exc_opcode | exc_ovf | exc_div0;
  // Cause codes 01/10/11 map to vector offsets 0/1/2.
  assign w_vec_offset = {30'b0, r_exc_cause} - 32'd1;

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pc_source <= '0;
      r_pc_write  <= 1'b0;
      r_epc_write <= 1'b0;
      r_epc_data  <= '0;
      r_jump_addr <= '0;
      r_mem_read  <= 1'b0;
      r_mem_addr  <= '0;
      r_exc_cause <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc_source <= w_pc_source;
      r_pc_write  <= w_pc_write;
      r_epc_write <= w_epc_write;
      r_epc_data  <= w_epc_data;
      r_jump_addr <= w_jump_addr;
      r_mem_read  <= w_mem_read;
      r_mem_addr  <= w_mem_addr;
      r_exc_cause <= w_exc_cause;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  // Next state plus the output values that state will present. Decisions are
  // taken from the request-edge inputs and registered immediately, so the
  // latched copy of the request lives in the output registers themselves.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_source = r_pc_source;
    w_pc_write  = 1'b0;
    w_epc_write = 1'b0;
    w_epc_data  = r_epc_data;
    w_jump_addr = r_jump_addr;
    w_mem_read  = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_exc_cause = r_exc_cause;
    w_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (w_any_exc) begin
            w_state_nxt = S_EXC_SAVE;
            w_epc_write = 1'b1;
            w_epc_data  = pc_in - 32'd4;
            if (exc_opcode)   w_exc_cause = 2'b01;
            else if (exc_ovf) w_exc_cause = 2'b10;
            else              w_exc_cause = 2'b11;
          end else begin
            w_state_nxt = S_RESOLVE;
            w_exc_cause = 2'b00;
            w_done      = 1'b1;
            case (pc_op_t'(pc_op))
              OP_SEQ: begin w_pc_source = 2'b00; w_pc_write = 1'b1;  end
              OP_BEQ: begin w_pc_source = 2'b01; w_pc_write = zero;  end
              OP_BNE: begin w_pc_source = 2'b01; w_pc_write = !zero; end
              OP_BLE: begin w_pc_source = 2'b01; w_pc_write = !gt;   end
              OP_BGT: begin w_pc_source = 2'b01; w_pc_write = gt;    end
              OP_J: begin
                w_pc_source = 2'b10;
                w_pc_write  = 1'b1;
                w_jump_addr = {pc_in[31:28], instr_index, 2'b00};
              end
              OP_JR:  begin w_pc_source = 2'b00; w_pc_write = 1'b1; end
              OP_RTE: begin w_pc_source = 2'b11; w_pc_write = 1'b1; end
              default: begin w_pc_source = 2'b00; w_pc_write = 1'b1; end
            endcase
          end
        end
      end

      S_RESOLVE: begin
        w_state_nxt = S_IDLE;
      end

      S_EXC_SAVE: begin
        w_state_nxt = S_EXC_READ;
        w_mem_read  = 1'b1;
        w_mem_addr  = VEC + w_vec_offset;
      end

      S_EXC_READ: begin
        if (mem_ready) begin
          w_state_nxt = S_EXC_LOAD;
          w_pc_source = 2'b10;
          w_pc_write  = 1'b1;
          w_done      = 1'b1;
          w_jump_addr = {24'b0, mem_data};
        end else begin
          w_mem_read  = 1'b1;
        end
      end

      S_EXC_LOAD: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy = (w_state_nxt != S_IDLE);
  end

  assign pc_source = r_pc_source;
  assign pc_write  = r_pc_write;
  assign epc_write = r_epc_write;
  assign epc_data  = r_epc_data;
  assign jump_addr = r_jump_addr;
  assign mem_read  = r_mem_read;
  assign mem_addr  = r_mem_addr;
  assign exc_cause = r_exc_cause;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table of single-cycle resolves plus
// hand-written exception, abort and busy-ignore sequences.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  pc_op = '0;
  logic        zero = 1'b0;
  logic        gt = 1'b0;
  logic        exc_opcode = 1'b0;
  logic        exc_ovf = 1'b0;
  logic        exc_div0 = 1'b0;
  logic [31:0] pc_in = '0;
  logic [25:0] instr_index = '0;
  logic        mem_ready = 1'b0;
  logic [7:0]  mem_data = '0;

  logic [1:0]  pc_source;
  logic        pc_write;
  logic        epc_write;
  logic [31:0] epc_data;
  logic [31:0] jump_addr;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [1:0]  exc_cause;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  pc_sequencer #(.VEC_BASE(253)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .pc_op(pc_op),
    .zero(zero), .gt(gt), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf),
    .exc_div0(exc_div0), .pc_in(pc_in), .instr_index(instr_index),
    .mem_ready(mem_ready), .mem_data(mem_data), .pc_source(pc_source),
    .pc_write(pc_write), .epc_write(epc_write), .epc_data(epc_data),
    .jump_addr(jump_addr), .mem_read(mem_read), .mem_addr(mem_addr),
    .exc_cause(exc_cause), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One-cycle request pulse; afterwards the bench sits in the first cycle
  // of the resulting state with the request flags already cleared.
  task automatic issue(input logic [2:0] op, input logic z, input logic g,
                       input logic eo, input logic eov, input logic ed,
                       input logic [31:0] pc, input logic [25:0] idx);
    pc_op = op; zero = z; gt = g;
    exc_opcode = eo; exc_ovf = eov; exc_div0 = ed;
    pc_in = pc; instr_index = idx;
    req = 1'b1;
    tick();
    req = 1'b0;
    zero = 1'b0; gt = 1'b0;
    exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        z;
    logic        g;
    logic [31:0] pc;
    logic [25:0] idx;
    logic [1:0]  src;
    logic        wr;
    logic [31:0] ja;
  } vec_t;

  vec_t tv[12];

  initial begin
    // op,    z,    g,    pc,            idx,       src,   wr,   jump_addr
    tv[0]  = '{3'b000, 1'b0, 1'b0, 32'h0000_1000, 26'h0,     2'b00, 1'b1, 32'h0};
    tv[1]  = '{3'b001, 1'b1, 1'b0, 32'h0000_1004, 26'h0,     2'b01, 1'b1, 32'h0};
    tv[2]  = '{3'b001, 1'b0, 1'b0, 32'h0000_1008, 26'h0,     2'b01, 1'b0, 32'h0};
    tv[3]  = '{3'b010, 1'b0, 1'b1, 32'h0000_100C, 26'h0,     2'b01, 1'b1, 32'h0};
    tv[4]  = '{3'b010, 1'b1, 1'b0, 32'h0000_1010, 26'h0,     2'b01, 1'b0, 32'h0};
    tv[5]  = '{3'b011, 1'b1, 1'b0, 32'h0000_1014, 26'h0,     2'b01, 1'b1, 32'h0};
    tv[6]  = '{3'b011, 1'b0, 1'b1, 32'h0000_1018, 26'h0,     2'b01, 1'b0, 32'h0};
    tv[7]  = '{3'b100, 1'b0, 1'b1, 32'h0000_101C, 26'h0,     2'b01, 1'b1, 32'h0};
    tv[8]  = '{3'b100, 1'b1, 1'b0, 32'h0000_1020, 26'h0,     2'b01, 1'b0, 32'h0};
    tv[9]  = '{3'b101, 1'b0, 1'b0, 32'hA000_0010, 26'h123,   2'b10, 1'b1, 32'hA000_048C};
    tv[10] = '{3'b110, 1'b0, 1'b0, 32'h0000_2000, 26'h3FF,   2'b00, 1'b1, 32'hA000_048C};
    tv[11] = '{3'b111, 1'b0, 1'b0, 32'h0000_3000, 26'h0,     2'b11, 1'b1, 32'hA000_048C};

    // Reset held with req toggling: every output stays at zero.
    for (int i = 0; i < 4; i++) begin
      req = ~req;
      pc_op = 3'b101; pc_in = 32'hFFFF_FFFF; instr_index = 26'h3FF_FFFF;
      tick();
      chk("rst_pc_write", {31'b0, pc_write}, 32'h0);
      chk("rst_busy",     {31'b0, busy},     32'h0);
      chk("rst_done",     {31'b0, done},     32'h0);
    end
    req = 1'b0;
    chk("rst_pc_source", {30'b0, pc_source}, 32'h0);
    chk("rst_epc_write", {31'b0, epc_write}, 32'h0);
    chk("rst_epc_data",  epc_data,           32'h0);
    chk("rst_jump_addr", jump_addr,          32'h0);
    chk("rst_mem_read",  {31'b0, mem_read},  32'h0);
    chk("rst_mem_addr",  mem_addr,           32'h0);
    chk("rst_exc_cause", {30'b0, exc_cause}, 32'h0);
    reset_n = 1'b1;
    tick();

    // Table of ordinary resolves, issued back to back every 2 cycles.
    for (int i = 0; i < 12; i++) begin
      issue(tv[i].op, tv[i].z, tv[i].g, 1'b0, 1'b0, 1'b0, tv[i].pc, tv[i].idx);
      chk($sformatf("v%0d_src", i),   {30'b0, pc_source}, {30'b0, tv[i].src});
      chk($sformatf("v%0d_wr", i),    {31'b0, pc_write},  {31'b0, tv[i].wr});
      chk($sformatf("v%0d_done", i),  {31'b0, done},      32'h1);
      chk($sformatf("v%0d_busy", i),  {31'b0, busy},      32'h1);
      chk($sformatf("v%0d_epcw", i),  {31'b0, epc_write}, 32'h0);
      chk($sformatf("v%0d_ja", i),    jump_addr,          tv[i].ja);
      chk($sformatf("v%0d_cause", i), {30'b0, exc_cause}, 32'h0);
      tick();
      chk($sformatf("v%0d_wr_off", i),   {31'b0, pc_write}, 32'h0);
      chk($sformatf("v%0d_done_off", i), {31'b0, done},     32'h0);
      chk($sformatf("v%0d_busy_off", i), {31'b0, busy},     32'h0);
    end

    // Overflow + div0 at pc 0x100: overflow wins, read stalls two cycles.
    issue(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 26'h0);
    chk("ex1_save_epcw",  {31'b0, epc_write}, 32'h1);
    chk("ex1_save_epcd",  epc_data,           32'h0000_00FC);
    chk("ex1_save_cause", {30'b0, exc_cause}, 32'h2);
    chk("ex1_save_busy",  {31'b0, busy},      32'h1);
    chk("ex1_save_pcw",   {31'b0, pc_write},  32'h0);
    chk("ex1_save_mrd",   {31'b0, mem_read},  32'h0);
    mem_ready = 1'b1; mem_data = 8'hEE;   // outside EXC_READ: must be ignored
    tick();
    mem_ready = 1'b0;
    chk("ex1_rd_mrd",   {31'b0, mem_read},  32'h1);
    chk("ex1_rd_addr",  mem_addr,           32'd254);
    chk("ex1_rd_epcw",  {31'b0, epc_write}, 32'h0);
    chk("ex1_rd_done",  {31'b0, done},      32'h0);
    tick();
    chk("ex1_rd2_mrd",  {31'b0, mem_read},  32'h1);
    chk("ex1_rd2_done", {31'b0, done},      32'h0);
    tick();
    chk("ex1_rd3_mrd",  {31'b0, mem_read},  32'h1);
    chk("ex1_rd3_pcw",  {31'b0, pc_write},  32'h0);
    mem_ready = 1'b1; mem_data = 8'h7C;
    tick();
    mem_ready = 1'b0; mem_data = 8'h00;
    chk("ex1_ld_done",  {31'b0, done},      32'h1);
    chk("ex1_ld_pcw",   {31'b0, pc_write},  32'h1);
    chk("ex1_ld_src",   {30'b0, pc_source}, 32'h2);
    chk("ex1_ld_ja",    jump_addr,          32'h0000_007C);
    chk("ex1_ld_mrd",   {31'b0, mem_read},  32'h0);
    chk("ex1_ld_cause", {30'b0, exc_cause}, 32'h2);
    tick();
    chk("ex1_end_busy",  {31'b0, busy},      32'h0);
    chk("ex1_end_done",  {31'b0, done},      32'h0);
    chk("ex1_end_cause", {30'b0, exc_cause}, 32'h2);
    chk("ex1_end_ja",    jump_addr,          32'h0000_007C);

    // Opcode + overflow at pc 0: opcode wins, EPC wraps; req during the
    // completing read cycle is dropped.
    issue(3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 26'h0);
    chk("ex2_save_epcd",  epc_data,           32'hFFFF_FFFC);
    chk("ex2_save_cause", {30'b0, exc_cause}, 32'h1);
    chk("ex2_save_epcw",  {31'b0, epc_write}, 32'h1);
    tick();
    chk("ex2_rd_addr",    mem_addr,           32'd253);
    chk("ex2_rd_mrd",     {31'b0, mem_read},  32'h1);
    mem_ready = 1'b1; mem_data = 8'h40;
    req = 1'b1; pc_op = 3'b000;
    tick();
    req = 1'b0; mem_ready = 1'b0;
    chk("ex2_ld_done",    {31'b0, done},      32'h1);
    chk("ex2_ld_ja",      jump_addr,          32'h0000_0040);
    tick();
    chk("ex2_drop_busy",  {31'b0, busy},      32'h0);
    chk("ex2_drop_done",  {31'b0, done},      32'h0);
    chk("ex2_drop_pcw",   {31'b0, pc_write},  32'h0);
    issue(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 26'h0);
    chk("rte_src",   {30'b0, pc_source}, 32'h3);
    chk("rte_pcw",   {31'b0, pc_write},  32'h1);
    chk("rte_cause", {30'b0, exc_cause}, 32'h0);
    tick();

    // req while busy is ignored.
    issue(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0500, 26'h0);
    chk("ign_first_done", {31'b0, done}, 32'h1);
    pc_op = 3'b101; pc_in = 32'hF000_0000; instr_index = 26'h1; req = 1'b1;
    tick();
    req = 1'b0;
    chk("ign_done", {31'b0, done},     32'h0);
    chk("ign_pcw",  {31'b0, pc_write}, 32'h0);
    chk("ign_busy", {31'b0, busy},     32'h0);
    chk("ign_ja",   jump_addr,         32'h0000_0040);
    tick();
    chk("ign_done2", {31'b0, done}, 32'h0);

    // Reset during EXC_READ aborts without any write.
    issue(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 26'h0);
    tick();
    chk("ab_rd_mrd", {31'b0, mem_read}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("ab_async_busy", {31'b0, busy},     32'h0);
    chk("ab_async_mrd",  {31'b0, mem_read}, 32'h0);
    chk("ab_async_ja",   jump_addr,         32'h0);
    tick();
    reset_n = 1'b1;
    mem_ready = 1'b1; mem_data = 8'h55;
    tick();
    chk("ab_post_busy", {31'b0, busy},     32'h0);
    chk("ab_post_pcw",  {31'b0, pc_write}, 32'h0);
    chk("ab_post_done", {31'b0, done},     32'h0);
    tick();
    mem_ready = 1'b0;
    chk("ab_post2_pcw",  {31'b0, pc_write}, 32'h0);
    chk("ab_post2_epcw", {31'b0, epc_write}, 32'h0);
    issue(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0600, 26'h0);
    chk("ab_seq_done", {31'b0, done},     32'h1);
    chk("ab_seq_pcw",  {31'b0, pc_write}, 32'h1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
